// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back, with a configurable stall in every memory-access state.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       iOrD,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluCtl,
  output logic [1:0] pcSrc,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic [3:0] state,
  output logic       instrDone
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtExec  = 4'd6,
    StRtWb    = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13
  } state_e;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpJal  = 6'h03;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluSlt = 3'b011;

  localparam logic [3:0] WaitCnt = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q;
  logic       wait_done;

  // Only meaningful in the stalled states; every other state lasts one cycle.
  assign wait_done = (cnt_q == WaitCnt);
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (wait_done) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw:     state_d = StMemAdr;
          OpR:            state_d = (funct == FnJr) ? StJr : StRtExec;
          OpAddi:         state_d = StIExec;
          OpBeq, OpBne:   state_d = StBranch;
          OpJ:            state_d = StJump;
          OpJal:          state_d = StJal;
          default:        state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (wait_done) state_d = StMemWb;
      StMemWr:  if (wait_done) state_d = StFetch;
      StRtExec: state_d = StRtWb;
      StIExec:  state_d = StIWb;
      StMemWb, StRtWb, StIWb, StBranch, StJump, StJal, StJr: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Counter restarts on every state change so each stalled state sees 0..MEM_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 4'd1;
    end
  end

  always_comb begin
    pcEn      = 1'b0;
    irWrite   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    iOrD      = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluCtl    = AluAdd;
    pcSrc     = 2'b00;
    regDst    = 2'b00;
    memToReg  = 2'b00;
    instrDone = 1'b0;
    unique case (state_q)
      StFetch: begin
        aluSrcB = 2'b01;
        irWrite = wait_done;
        pcEn    = wait_done;
      end
      StDecode: begin
        aluSrcB   = 2'b11;
        // Only an unrecognised opcode returns straight to fetch.
        instrDone = (state_d == StFetch);
      end
      StMemAdr, StIExec: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      StMemRd: iOrD = 1'b1;
      StMemWb: begin
        memToReg  = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StMemWr: begin
        iOrD      = 1'b1;
        memWrite  = wait_done;
        instrDone = wait_done;
      end
      StRtExec: begin
        aluSrcA = 1'b1;
        case (funct)
          FnSub:   aluCtl = AluSub;
          FnSlt:   aluCtl = AluSlt;
          FnAdd:   aluCtl = AluAdd;
          default: aluCtl = AluAdd;
        endcase
      end
      StRtWb: begin
        regDst    = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StIWb: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StBranch: begin
        aluSrcA   = 1'b1;
        aluCtl    = AluSub;
        pcSrc     = 2'b01;
        pcEn      = (op == OpBeq) ? zero : ~zero;
        instrDone = 1'b1;
      end
      StJump: begin
        pcSrc     = 2'b10;
        pcEn      = 1'b1;
        instrDone = 1'b1;
      end
      StJal: begin
        pcSrc     = 2'b10;
        pcEn      = 1'b1;
        regWrite  = 1'b1;
        regDst    = 2'b10;
        memToReg  = 2'b10;
        instrDone = 1'b1;
      end
      StJr: begin
        pcSrc     = 2'b11;
        pcEn      = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcEn      = 1'b0;
      irWrite   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      instrDone = 1'b0;
    end
  end

endmodule
